// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared FSM state encoding and defaults for the wait-state memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
    localparam int          CNT_W         = 4;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-port DEPTH x DATA_W storage, byte write enables, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         idx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int BYTES = DATA_W / 8;

    // Contents start at zero and are deliberately left out of the reset domain.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register holds its value until the next read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_array
`default_nettype wire

// File: rtl/data_mem_wait.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_wait
// Description : Data memory with programmable wait states, range/alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_wait
    import mem_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  rvalid,
    output logic                  addr_err
);

    localparam int          BYTES     = DATA_W / 8;
    localparam int          LSB       = $clog2(BYTES);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN      = 33'(longint'(DEPTH) * longint'(BYTES));
    localparam logic [31:0] LSB_MASK  = 32'(BYTES - 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [BYTES-1:0]     be_q, be_d;
    logic                 wr_q, wr_d;
    logic                 err_q, err_d;

    logic [31:0]          w_off;
    logic                 w_in_range;
    logic                 w_aligned;
    logic                 w_req;
    logic                 w_illegal;
    logic [AW-1:0]        w_idx;

    logic                 w_commit;
    logic                 w_commit_wr;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [AW-1:0]        w_mem_idx;
    logic [DATA_W-1:0]    w_mem_wdata;
    logic [BYTES-1:0]     w_mem_be;

    // Offset compared on 33 bits so the window end cannot wrap.
    assign w_off      = addr - BASE_ADDR;
    assign w_in_range = (addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
    assign w_aligned  = (addr & LSB_MASK) == 32'd0;
    assign w_idx      = AW'(w_off >> LSB);
    assign w_req      = req_rd | req_wr;
    assign w_illegal  = (req_rd & req_wr) | ~w_in_range | ~w_aligned;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        wr_d        = wr_q;
        err_d       = err_q;
        w_commit    = 1'b0;
        w_commit_wr = wr_q;
        w_mem_idx   = idx_q;
        w_mem_wdata = wdata_q;
        w_mem_be    = be_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    idx_d   = w_idx;
                    wdata_d = wdata;
                    be_d    = byte_en;
                    wr_d    = req_wr;
                    err_d   = w_illegal;
                    cnt_d   = WAIT_INIT;
                    if (w_illegal) begin
                        state_d = ST_DONE;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero-wait access commits straight from the live inputs.
                        state_d     = ST_DONE;
                        w_commit    = 1'b1;
                        w_commit_wr = req_wr;
                        w_mem_idx   = w_idx;
                        w_mem_wdata = wdata;
                        w_mem_be    = byte_en;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    w_commit = 1'b1;
                end
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_mem_we = w_commit & w_commit_wr;
    assign w_mem_re = w_commit & ~w_commit_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    assign ready    = (state_q == ST_DONE);
    assign rvalid   = ready & ~wr_q & ~err_q;
    assign addr_err = ready & err_q;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_mem_we),
        .re_i    (w_mem_re),
        .idx_i   (w_mem_idx),
        .wdata_i (w_mem_wdata),
        .be_i    (w_mem_be),
        .rdata_o (rdata)
    );

endmodule : data_mem_wait
`default_nettype wire

// File: tb/tb_data_mem_wait.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_wait
// Description : Self-checking bench for data_mem_wait (2-wait and 0-wait builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_wait;

    localparam int WAITS = 2;

    logic        clk;
    logic        rst_n;

    logic        req_rd, req_wr;
    logic [31:0] addr, wdata;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        ready, rvalid, addr_err;

    logic        r0_rd, r0_wr;
    logic [31:0] r0_addr, r0_wdata;
    logic [3:0]  r0_be;
    logic [31:0] w0_rdata;
    logic        w0_ready, w0_rvalid, w0_err;

    int checks;
    int errors;

    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdata;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          lat;
        logic        err;
        logic        rv;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs [15];

    int          a_lat, e_lat;
    logic        a_err, a_rv, e_err, e_rv;
    logic [31:0] a_rdat, e_rdat;
    logic [31:0] r_addr, r_data;
    logic [3:0]  r_be;
    logic        r_rd, r_wr;
    int          sel, op;

    data_mem_wait #(
        .DATA_W(32), .DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(WAITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
        .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .rdata(rdata), .ready(ready), .rvalid(rvalid), .addr_err(addr_err)
    );

    data_mem_wait #(
        .DATA_W(32), .DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .req_rd(r0_rd), .req_wr(r0_wr),
        .addr(r0_addr), .wdata(r0_wdata), .byte_en(r0_be),
        .rdata(w0_rdata), .ready(w0_ready), .rvalid(w0_rvalid), .addr_err(w0_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: legality and latency straight from the address map rules.
    function automatic void model(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] be,
                                  output int lat, output logic err, output logic rv,
                                  output logic [31:0] rdat);
        longint off;
        int     idx;
        off = longint'(a) - 64'd1024;
        err = (rd && wr) || (off < 0) || (off >= 256) || (a % 4 != 0);
        lat = err ? 1 : WAITS + 1;
        rv  = !err && rd;
        if (!err) begin
            idx = int'(off / 4);
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                ref_rdata = ref_mem[idx];
            end
        end
        rdat = ref_rdata;
    endfunction

    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              output int lat, output logic err, output logic rv,
                              output logic [31:0] rdat);
        @(posedge clk); #1;
        req_rd = rd; req_wr = wr; addr = a; wdata = d; byte_en = be;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                addr    = $urandom;
                wdata   = $urandom;
                byte_en = 4'($urandom);
            end
        end while (!ready && lat < 20);
        err  = addr_err;
        rv   = rvalid;
        rdat = rdata;
        req_rd = 1'b0;
        req_wr = 1'b0;
    endtask

    task automatic compare(input string tag);
        check({tag, "_latency"}, 32'(a_lat), 32'(e_lat));
        check({tag, "_addr_err"}, 32'(a_err), 32'(e_err));
        check({tag, "_rvalid"}, 32'(a_rv), 32'(e_rv));
        check({tag, "_rdata"}, a_rdat, e_rdat);
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        req_rd = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0; byte_en = '0;
        r0_rd = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_wdata = '0; r0_be = '0;
        checks = 0; errors = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        ref_rdata = '0;

        vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 4'hF, 3, 1'b0, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        4'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'd1028, 32'h11223344, 4'hF, 3, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'd1028, 32'h000000AA, 4'h1, 3, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        4'h0, 3, 1'b0, 1'b1, 32'h112233AA};
        vecs[5]  = '{1'b1, 1'b0, 32'd1020, 32'h0,        4'h0, 1, 1'b1, 1'b0, 32'h112233AA};
        vecs[6]  = '{1'b1, 1'b0, 32'd1280, 32'h0,        4'h0, 1, 1'b1, 1'b0, 32'h112233AA};
        vecs[7]  = '{1'b1, 1'b0, 32'd1026, 32'h0,        4'h0, 1, 1'b1, 1'b0, 32'h112233AA};
        vecs[8]  = '{1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, 4'hF, 3, 1'b0, 1'b0, 32'h112233AA};
        vecs[9]  = '{1'b1, 1'b0, 32'd1276, 32'h0,        4'h0, 3, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 1'b1, 32'd1024, 32'h0,        4'hF, 1, 1'b1, 1'b0, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 1'b1, 32'd1024, 32'hFFFFFFFF, 4'h0, 3, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[12] = '{1'b1, 1'b0, 32'd1024, 32'h0,        4'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[13] = '{1'b0, 1'b1, 32'd1024, 32'h00ABCD00, 4'h6, 3, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[14] = '{1'b1, 1'b0, 32'd1024, 32'h0,        4'h0, 3, 1'b0, 1'b1, 32'hDEABCDEF};

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_addr_err", 32'(addr_err), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ready_w0", 32'(w0_ready), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            model(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be, e_lat, e_err, e_rv, e_rdat);
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be,
                       a_lat, a_err, a_rv, a_rdat);
            e_lat = vecs[i].lat; e_err = vecs[i].err; e_rv = vecs[i].rv; e_rdat = vecs[i].rdat;
            compare($sformatf("vec%0d", i));
        end

        // Reset while a write to 1032 is still waiting: the write must vanish.
        @(posedge clk); #1;
        req_wr = 1'b1; addr = 32'd1032; wdata = 32'h55; byte_en = 4'hF;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset_ready", 32'(ready), 32'd0);
        check("midreset_rvalid", 32'(rvalid), 32'd0);
        check("midreset_addr_err", 32'(addr_err), 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        req_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_rdata = '0;
        model(1'b1, 1'b0, 32'd1032, 32'h0, 4'h0, e_lat, e_err, e_rv, e_rdat);
        run_access(1'b1, 1'b0, 32'd1032, 32'h0, 4'h0, a_lat, a_err, a_rv, a_rdat);
        compare("read_after_reset");

        for (int i = 0; i < 80; i++) begin
            sel    = int'($urandom_range(0, 9));
            r_addr = 32'd1024 + 32'(4 * $urandom_range(0, 15));
            if (sel == 0)      r_addr = 32'd1024 - 32'(4 * $urandom_range(1, 8));
            else if (sel == 1) r_addr = 32'd1280 + 32'(4 * $urandom_range(0, 8));
            else if (sel == 2) r_addr = r_addr + 32'($urandom_range(1, 3));
            op   = int'($urandom_range(0, 6));
            r_rd = (op == 0) || (op >= 4);
            r_wr = (op <= 3);
            r_data = $urandom;
            r_be   = 4'($urandom);
            model(r_rd, r_wr, r_addr, r_data, r_be, e_lat, e_err, e_rv, e_rdat);
            run_access(r_rd, r_wr, r_addr, r_data, r_be, a_lat, a_err, a_rv, a_rdat);
            compare($sformatf("rand%0d", i));
        end

        // Zero-wait build: held request completes every other cycle.
        @(posedge clk); #1;
        r0_wr = 1'b1; r0_addr = 32'd1024; r0_wdata = 32'h12345678; r0_be = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("w0_ready_pattern_%0d", k), 32'(w0_ready), 32'(k % 2));
        end
        r0_wr = 1'b0; r0_rd = 1'b1;
        @(posedge clk); #1;
        check("w0_read_ready", 32'(w0_ready), 32'd1);
        check("w0_read_rvalid", 32'(w0_rvalid), 32'd1);
        check("w0_read_addr_err", 32'(w0_err), 32'd0);
        check("w0_read_rdata", w0_rdata, 32'h12345678);
        r0_wr = 1'b1;
        @(posedge clk); #1;
        check("w0_done_ignores_req", 32'(w0_ready), 32'd0);
        @(posedge clk); #1;
        check("w0_both_ready", 32'(w0_ready), 32'd1);
        check("w0_both_addr_err", 32'(w0_err), 32'd1);
        check("w0_both_rvalid", 32'(w0_rvalid), 32'd0);
        check("w0_both_rdata", w0_rdata, 32'h12345678);
        r0_rd = 1'b0; r0_wr = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_mem_wait
`default_nettype wire

// File: doc/data_mem_wait.md
DATA_MEM_WAIT -- requirements
Module: data_mem_wait

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 64, number of words (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 1024, byte address of word 0.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, extra stall cycles per legal access (0..15).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_rd  input  1  read request, held by requester until ready.
REQ-008 SHALL have port req_wr  input  1  write request, held by requester until ready.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  DATA_W  write data.
REQ-011 SHALL have port byte_en  input  DATA_W/8  per-byte write enable.
REQ-012 SHALL have port rdata  output  DATA_W  read data, registered.
REQ-013 SHALL have port ready  output  1  one-cycle pulse: access complete, pipeline may advance.
REQ-014 SHALL have port rvalid  output  1  one-cycle pulse with ready on a successful read.
REQ-015 SHALL have port addr_err  output  1  one-cycle pulse with ready on an illegal access.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-017 IDLE: on req_rd xor req_wr, SHALL capture addr, wdata, byte_en, op into registers, load wait counter with WAIT_CYCLES, and go to WAIT (legal, WAIT_CYCLES>0) or DONE (legal, WAIT_CYCLES=0, or illegal).
REQ-018 WAIT: SHALL decrement counter each cycle and go to DONE on the cycle the counter reaches 1.
REQ-019 DONE: SHALL assert ready for exactly one cycle, then return to IDLE; a request seen in DONE is ignored and accepted in the following IDLE cycle.
REQ-020 Legal-access latency SHALL be WAIT_CYCLES+1 cycles from request acceptance edge to ready high.
REQ-021 Word index SHALL be (addr - BASE_ADDR) >> log2(DATA_W/8), computed on 32 bits.
REQ-022 Access SHALL be illegal when addr < BASE_ADDR, addr >= BASE_ADDR + DEPTH*DATA_W/8, or low log2(DATA_W/8) address bits are nonzero.
REQ-023 Illegal access SHALL complete at latency 1 with addr_err=1, no memory write, rvalid=0, rdata unchanged.
REQ-024 Legal write SHALL update only bytes with byte_en=1, at the edge entering DONE; byte_en=0 gives a completed no-op write.
REQ-025 Legal read SHALL load rdata at the edge entering DONE; rvalid=1 in DONE; rdata SHALL hold until the next successful read.
REQ-026 req_rd and req_wr both high in IDLE SHALL be treated as illegal (addr_err pulse, no access).
REQ-027 Input changes after acceptance SHALL not affect the access in progress.
REQ-028 Read after write to same word SHALL return the written data (no bypass needed; accesses are serialised).

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter 0, ready=0, rvalid=0, addr_err=0, rdata=0.
REQ-030 Reset mid-access SHALL cancel the pending access; a write not yet committed SHALL not occur.
REQ-031 Memory array contents SHALL not be altered by reset; array SHALL initialise to zero at time zero.

Structure
REQ-032 Package mem_pkg SHALL hold the FSM state enum and default BASE_ADDR constant.
REQ-033 Storage SHALL be a sub-module mem_array (DEPTH x DATA_W, one synchronous port, byte-write enables, registered read).
REQ-034 FSM, counter, range check and request capture SHALL live in data_mem_wait.

Verification
REQ-035 Reset release, WAIT_CYCLES=2, write 0xDEADBEEF at 1024, byte_en=0xF -> ready high on 3rd cycle after acceptance, addr_err=0.
REQ-036 Read 1024 after REQ-035 -> ready and rvalid together, rdata=0xDEADBEEF, latency 3 cycles.
REQ-037 Write 0x000000AA at 1028 with byte_en=0x1 over prior 0x11223344 -> read returns 0x112233AA.
REQ-038 Read addr 1020, addr 1280, addr 1026 -> each ready at latency 1 with addr_err=1, rvalid=0, rdata unchanged.
REQ-039 Assert rst_n low in WAIT of write 0x55 to 1032 -> outputs 0, subsequent read of 1032 returns prior value 0.
REQ-040 WAIT_CYCLES=0 back-to-back held requests -> ready every 2 cycles, req_rd and req_wr together -> addr_err=1.
